// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the MIPS32 fetch stage: the fetch-queue entry, the fetch FSM
// states and the default boot PC.
package instr_fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  adel;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } ifu_state_t;

    localparam word_t IFU_RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Circular FIFO of fetch entries between the bus side and decode.
// Flush empties it in one cycle; storage itself is never reset.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

    // A push into a full queue is only taken when a pop frees the slot the same cycle.
    assign w_push = i_push && (!o_full || i_pop);
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_tail] <= i_entry;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS32 fetch stage: PC generation, single-outstanding SRAM-like instruction bus
// reads, fetch queue towards decode, redirect flush with stale-response discard.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    ifu_state_t    r_state;
    ifu_state_t    w_state_nxt;
    word_t         r_pc;
    word_t         r_req_pc;
    logic          r_halt;
    logic          r_live;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_slot;
    logic          w_can_issue;
    logic          w_adel_push;
    logic          w_data_push;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;

    // r_live keeps the bus quiet for the first cycle after reset is released.
    assign w_slot      = (r_state == IDLE) ? !w_full
                                           : (32'(w_count) < 32'(QUEUE_DEPTH - 1));
    assign w_can_issue = resetn && r_live && (r_state == IDLE) && !r_halt
                         && !redirect_valid && w_slot;

    assign inst_req    = w_can_issue && (r_pc[1:0] == 2'b00);
    assign inst_addr   = r_pc;
    assign w_accept    = inst_req && inst_addr_ok;

    assign w_adel_push = w_can_issue && (r_pc[1:0] != 2'b00);
    assign w_data_push = (r_state == WAIT) && inst_data_ok && !redirect_valid;
    assign w_push      = w_adel_push || w_data_push;

    always_comb begin
        w_push_entry = '{pc: r_req_pc, instr: inst_rdata, adel: 1'b0};
        if (w_adel_push) w_push_entry = '{pc: r_pc, instr: '0, adel: 1'b1};
    end

    assign out_valid = resetn && !w_empty && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign out_adel  = w_head.adel;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_push   (w_push),
        .i_entry  (w_push_entry),
        .i_pop    (w_pop),
        .i_flush  (redirect_valid),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // A redirect while waiting leaves a response in flight; DISCARD swallows it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)          w_state_nxt = WAIT;
            WAIT:    if (inst_data_ok)      w_state_nxt = IDLE;
                     else if (redirect_valid) w_state_nxt = DISCARD;
            DISCARD: if (inst_data_ok)      w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc   <= RESET_PC;
            r_halt <= 1'b0;
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (redirect_valid) begin
                r_pc   <= redirect_pc;
                r_halt <= 1'b0;
            end else begin
                if (w_accept)    r_pc   <= r_pc + 32'd4;
                if (w_adel_push) r_halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_req_pc <= r_pc;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: responsive bus model plus an in-order stream model
// of the fetched sequence, driven by directed steps and a randomized phase.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_adel       (out_adel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs
    int          k_ready_pct = 100;
    int          k_addr_pct  = 100;
    int          k_lat_min   = 0;
    int          k_lat_max   = 0;
    logic        k_redir     = 1'b0;
    logic [31:0] k_rpc       = '0;
    logic        k_data_ovr  = 1'b0;
    logic [31:0] k_data      = '0;
    logic        k_rst       = 1'b1;

    // bus responder
    logic        bus_out  = 1'b0;
    logic [31:0] bus_addr = '0;
    int          bus_lat  = 0;

    // reference model: the next PC decode should see and the next PC the bus should be asked for
    logic [31:0] m_out_pc   = RST_PC;
    logic [31:0] m_req_pc   = RST_PC;
    logic        m_halted   = 1'b0;
    int          m_inflight = 0;
    int          m_pops     = 0;
    int          m_reqs     = 0;
    logic        was_rst    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h1357_9bdf;
    endfunction

    task automatic model_flush(input logic [31:0] pc);
        m_out_pc   = pc;
        m_req_pc   = pc;
        m_halted   = 1'b0;
        m_inflight = 0;
    endtask

    task automatic step();
        logic        exp_adel;
        logic [31:0] exp_instr;
        @(posedge clk);
        #1;
        resetn         = !k_rst;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        out_ready      = (int'($urandom_range(99)) < k_ready_pct);
        inst_addr_ok   = (int'($urandom_range(99)) < k_addr_pct);
        inst_data_ok   = 1'b0;
        inst_rdata     = $urandom;
        if (k_rst) begin
            bus_out = 1'b0;
        end else if (bus_out) begin
            if (bus_lat == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = k_data_ovr ? k_data : mem_word(bus_addr);
            end else begin
                bus_lat--;
            end
        end
        k_redir = 1'b0;
        @(negedge clk);
        if (!resetn) begin
            chk("rst_req", inst_req, 0);
            chk("rst_valid", out_valid, 0);
            model_flush(RST_PC);
            was_rst = 1'b1;
        end else begin
            if (was_rst) begin
                chk("post_rst_req", inst_req, 0);
                chk("post_rst_valid", out_valid, 0);
            end
            was_rst = 1'b0;
            if (inst_req) chk("req_while_busy", bus_out, 0);
            if (inst_data_ok) bus_out = 1'b0;
            if (redirect_valid) begin
                chk("redir_valid", out_valid, 0);
                chk("redir_req", inst_req, 0);
                model_flush(redirect_pc);
            end else begin
                if (m_halted) chk("halted_valid", out_valid, 0);
                if (out_valid && out_ready) begin
                    exp_adel  = (m_out_pc[1:0] != 2'b00);
                    exp_instr = exp_adel ? 32'h0 : mem_word(m_out_pc);
                    chk("out_pc", out_pc, m_out_pc);
                    chk("out_instr", out_instr, exp_instr);
                    chk("out_adel", out_adel, exp_adel);
                    if (exp_adel) m_halted = 1'b1;
                    m_out_pc = m_out_pc + 32'd4;
                    m_inflight--;
                    m_pops++;
                end
                if (inst_req) begin
                    chk("req_addr", inst_addr, m_req_pc);
                    if (inst_addr_ok) begin
                        bus_out  = 1'b1;
                        bus_addr = inst_addr;
                        bus_lat  = int'($urandom_range(k_lat_max, k_lat_min));
                        m_req_pc = m_req_pc + 32'd4;
                        m_inflight++;
                        m_reqs++;
                    end
                end
                chk("inflight_bound", 32'(m_inflight <= DEPTH), 1);
            end
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        do begin
            step();
            n++;
        end while (!inst_req && n < 60);
        chk({tag, "_seen"}, inst_req, 1);
        chk(tag, inst_addr, exp_addr);
    endtask

    task automatic wait_bus_busy(input string tag);
        int n = 0;
        while (!bus_out && n < 60) begin
            step();
            n++;
        end
        chk(tag, bus_out, 1);
    endtask

    initial begin
        int snap;
        // reset held, then released; the first cycle after release must stay quiet
        k_rst = 1'b1;
        repeat (3) step();
        k_rst = 1'b0;

        // decode stalled: exactly DEPTH words fetched, then the bus goes idle
        k_ready_pct = 0;
        k_addr_pct  = 100;
        repeat (30) step();
        chk("stall_reqs", m_reqs, 4);
        chk("stall_req_idle", inst_req, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_pops", m_pops, 0);
        chk("stall_head", out_pc, RST_PC);

        // release: entries drain in order, fetching resumes after the fourth word
        k_ready_pct = 100;
        wait_req("resume_addr", 32'hbfc0_0010);
        repeat (10) step();
        chk("drain_some", 32'(m_pops >= 3), 1);

        // redirect while a read is in flight; the stale word must vanish
        k_lat_min = 2;
        k_lat_max = 2;
        wait_bus_busy("wait_busy_1");
        k_redir    = 1'b1;
        k_rpc      = 32'h8000_0180;
        k_data_ovr = 1'b1;
        k_data     = 32'hdead_beef;
        step();
        for (int i = 0; i < 10 && bus_out; i++) step();
        chk("stale_returned", bus_out, 0);
        k_data_ovr = 1'b0;
        k_lat_min  = 0;
        k_lat_max  = 1;
        wait_req("after_redir_addr", 32'h8000_0180);
        snap = m_pops;
        repeat (12) step();
        chk("after_redir_pops", 32'(m_pops > snap), 1);

        // misaligned target: one address-error entry, no bus traffic, halt
        k_redir = 1'b1;
        k_rpc   = 32'h0040_0002;
        step();
        for (int i = 0; i < 10 && bus_out; i++) step();
        snap = m_reqs;
        repeat (15) step();
        chk("adel_no_req", m_reqs - snap, 0);
        chk("adel_halted", m_halted, 1);
        chk("adel_idle_req", inst_req, 0);
        k_redir = 1'b1;
        k_rpc   = 32'h0040_0000;
        step();
        wait_req("adel_resume_addr", 32'h0040_0000);
        snap = m_pops;
        repeat (15) step();
        chk("adel_resume_pops", 32'(m_pops - snap >= 2), 1);

        // redirect coinciding with data_ok and a would-be pop
        k_ready_pct = 0;
        k_lat_min   = 0;
        k_lat_max   = 0;
        for (int i = 0; i < 40 && !(bus_out && out_valid); i++) step();
        chk("combo_setup", 32'(bus_out && out_valid), 1);
        k_ready_pct = 100;
        k_redir     = 1'b1;
        k_rpc       = 32'h0000_1000;
        step();
        chk("combo_dok", inst_data_ok, 1);
        step();
        chk("combo_next_valid", out_valid, 0);
        chk("combo_next_req", inst_req, 1);
        chk("combo_next_addr", inst_addr, 32'h0000_1000);

        // PC wraps across 2^32
        k_lat_max = 1;
        k_redir   = 1'b1;
        k_rpc     = 32'hffff_fff8;
        step();
        snap = m_pops;
        repeat (25) step();
        chk("wrap_pops", 32'(m_pops - snap >= 3), 1);

        // reset asserted while a read is outstanding
        k_lat_min = 3;
        k_lat_max = 3;
        wait_bus_busy("wait_busy_2");
        k_rst = 1'b1;
        step();
        k_rst = 1'b0;
        k_lat_min = 0;
        k_lat_max = 2;
        wait_req("post_reset_addr", RST_PC);

        // randomized traffic with occasional redirects
        for (int blk = 0; blk < 15; blk++) begin
            k_ready_pct = int'($urandom_range(100, 30));
            k_addr_pct  = int'($urandom_range(100, 50));
            k_lat_max   = int'($urandom_range(3, 0));
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(99) < 3) begin
                    k_redir = 1'b1;
                    k_rpc   = {$urandom_range(32'h0fff_ffff, 0), 2'b00} << 2;
                    if ($urandom_range(4) == 0) k_rpc[1:0] = 2'($urandom_range(3, 1));
                end
                step();
            end
        end
        chk("random_progress", 32'(m_pops > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
